// File: rtl/npu_lb_pkg.sv
// Shared definitions for the 3x3 line-buffer sequencer: FSM states and
// buffer geometry / memory latency constants.
package npu_lb_pkg;

   localparam int unsigned LB_ROWS    = 3;
   localparam int unsigned LB_DEPTH   = 3;
   localparam int unsigned MEM_RD_LAT = 1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WRITE,
      SHIFT,
      FLUSH,
      NEXT_ROW,
      DONE
   } lb_state_e;

endpackage

// File: rtl/linebuffer_ctrl_if.sv
// Frame command, memory read and line-buffer strobe bundle between the
// sequencer (master) and its parent (slave).
interface linebuffer_ctrl_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DIM_W  = 10
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [DIM_W-1:0]  img_width;
   logic [DIM_W-1:0]  img_height;
   logic              stall;
   logic              busy;
   logic              done;
   logic              err;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr_r1;
   logic [ADDR_W-1:0] mem_addr_r2;
   logic [ADDR_W-1:0] mem_addr_r3;
   logic              lb_wr_en;
   logic              lb_shift;
   logic              out_valid;
   logic [DIM_W-1:0]  out_row;
   logic [DIM_W-1:0]  out_col;

   modport master (
      input  start, base_addr, img_width, img_height, stall,
      output busy, done, err, mem_rd_en, mem_addr_r1, mem_addr_r2, mem_addr_r3,
             lb_wr_en, lb_shift, out_valid, out_row, out_col
   );

   modport slave (
      output start, base_addr, img_width, img_height, stall,
      input  busy, done, err, mem_rd_en, mem_addr_r1, mem_addr_r2, mem_addr_r3,
             lb_wr_en, lb_shift, out_valid, out_row, out_col
   );
endinterface

// File: rtl/linebuffer_addr_gen.sv
// Column / band-base counters and the three row read addresses. The band
// base is a running sum of the width, so no multiplier is needed.
module linebuffer_addr_gen #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DIM_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              col_inc_i,
   input  logic              next_row_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [DIM_W-1:0]  width_i,
   output logic [DIM_W-1:0]  col_o,
   output logic [ADDR_W-1:0] addr_r1_o,
   output logic [ADDR_W-1:0] addr_r2_o,
   output logic [ADDR_W-1:0] addr_r3_o
);

   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [DIM_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] w_ext;

   assign w_ext = ADDR_W'(width_i);

   always_comb begin
      row_base_d = row_base_q;
      col_d      = col_q;
      if (clr_i) begin
         row_base_d = '0;
         col_d      = '0;
      end else if (next_row_i) begin
         row_base_d = row_base_q + w_ext;
         col_d      = '0;
      end else if (col_inc_i) begin
         col_d = col_q + DIM_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_base_q <= '0;
         col_q      <= '0;
      end else begin
         row_base_q <= row_base_d;
         col_q      <= col_d;
      end
   end

   // All sums wrap modulo 2^ADDR_W.
   assign col_o     = col_q;
   assign addr_r1_o = base_i + row_base_q + ADDR_W'(col_q);
   assign addr_r2_o = addr_r1_o + w_ext;
   assign addr_r3_o = addr_r1_o + (w_ext << 1);

endmodule

// File: rtl/linebuffer_ctrl.sv
// Band-by-band sequencer for the 3-row line buffer: three row reads per
// column, then mutually exclusive write/shift strobes and tail-valid flags.
module linebuffer_ctrl
   import npu_lb_pkg::*;
#(
   parameter int unsigned BIT_DEPTH = 8,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DIM_W     = 10
) (
   input logic               clk,
   input logic               rst,
   linebuffer_ctrl_if.master lb_if
);

   localparam int unsigned DW1 = DIM_W + 1;

   if (BIT_DEPTH == 0 || MEM_RD_LAT != 1 || LB_ROWS != 3 || LB_DEPTH != 3) begin : g_cfg_chk
      $error("linebuffer_ctrl: unsupported configuration");
   end

   lb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DIM_W-1:0]  w_q, w_d, h_q, h_d, row_q, row_d;
   logic              bad_q, bad_d;

   logic              clr, col_inc, next_row, mem_rd_en_c;
   logic [DIM_W-1:0]  col;
   logic              last_col, last_band;
   logic [ADDR_W-1:0] addr_r1, addr_r2, addr_r3;

   logic              busy_q, done_q, err_q, lb_wr_en_q, lb_shift_q, out_valid_q;
   logic [DIM_W-1:0]  out_row_q, out_col_q;

   linebuffer_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .col_inc_i  (col_inc),
      .next_row_i (next_row),
      .base_i     (base_q),
      .width_i    (w_q),
      .col_o      (col),
      .addr_r1_o  (addr_r1),
      .addr_r2_o  (addr_r2),
      .addr_r3_o  (addr_r3)
   );

   // Widened compares so W-1 / H-3 never underflow.
   assign last_col  = (DW1'(col) + DW1'(1)) >= DW1'(w_q);
   assign last_band = (DW1'(row_q) + DW1'(1)) > (DW1'(h_q) - DW1'(3));

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      w_d         = w_q;
      h_d         = h_q;
      row_d       = row_q;
      bad_d       = bad_q;
      clr         = 1'b0;
      col_inc     = 1'b0;
      next_row    = 1'b0;
      mem_rd_en_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (lb_if.start) begin
               base_d = lb_if.base_addr;
               w_d    = lb_if.img_width;
               h_d    = lb_if.img_height;
               row_d  = '0;
               clr    = 1'b1;
               if (lb_if.img_width == '0 || lb_if.img_height < DIM_W'(3)) begin
                  bad_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  bad_d   = 1'b0;
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            if (!lb_if.stall) begin
               mem_rd_en_c = 1'b1;
               state_d     = WRITE;
            end
         end
         WRITE: state_d = SHIFT;
         SHIFT: begin
            if (last_col) begin
               state_d = FLUSH;
            end else begin
               col_inc = 1'b1;
               state_d = FETCH;
            end
         end
         FLUSH: state_d = NEXT_ROW;
         NEXT_ROW: begin
            next_row = 1'b1;
            row_d    = row_q + DIM_W'(1);
            state_d  = last_band ? DONE : FETCH;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         w_q     <= '0;
         h_q     <= '0;
         row_q   <= '0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         w_q     <= w_d;
         h_q     <= h_d;
         row_q   <= row_d;
         bad_q   <= bad_d;
      end
   end

   // Strobes are registered from the next state; tail-valid lags SHIFT/FLUSH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         lb_wr_en_q  <= 1'b0;
         lb_shift_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
      end else begin
         busy_q      <= (state_d != IDLE);
         done_q      <= (state_d == DONE);
         err_q       <= (state_d == DONE) && bad_d;
         lb_wr_en_q  <= (state_d == WRITE);
         lb_shift_q  <= (state_d == SHIFT) || (state_d == FLUSH);
         out_valid_q <= ((state_q == SHIFT) && (col != '0)) || (state_q == FLUSH);
         if (state_q == FLUSH) begin
            out_row_q <= row_q;
            out_col_q <= w_q - DIM_W'(1);
         end else if ((state_q == SHIFT) && (col != '0)) begin
            out_row_q <= row_q;
            out_col_q <= col - DIM_W'(1);
         end
      end
   end

   assign lb_if.busy        = busy_q;
   assign lb_if.done        = done_q;
   assign lb_if.err         = err_q;
   assign lb_if.mem_rd_en   = mem_rd_en_c;
   assign lb_if.mem_addr_r1 = addr_r1;
   assign lb_if.mem_addr_r2 = addr_r2;
   assign lb_if.mem_addr_r3 = addr_r3;
   assign lb_if.lb_wr_en    = lb_wr_en_q;
   assign lb_if.lb_shift    = lb_shift_q;
   assign lb_if.out_valid   = out_valid_q;
   assign lb_if.out_row     = out_row_q;
   assign lb_if.out_col     = out_col_q;

endmodule
